// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA raster timing generator. Produces pixel
//                coordinates, registered sync with selectable polarity,
//                blanking flags, line/frame strobes and a frame counter.
//                A pixel enable lets the raster run slower than clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_DISPLAY  = 800,
    parameter int H_FRONT    = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BACK     = 64,
    parameter int V_DISPLAY  = 600,
    parameter int V_FRONT    = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 23,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int CNT_W      = 12,
    parameter int FRAME_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               video_on,
    output logic               hblank,
    output logic               vblank,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    // Totals are plain integers; every boundary used in a compare is then
    // narrowed to the counter width so all comparisons are CNT_W unsigned.
    localparam int c_h_total = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_disp     = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] c_v_disp     = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] c_hs_start   = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] c_hs_end     = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] c_vs_start   = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] c_vs_end     = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic             c_hs_active  = (H_SYNC_POL != 0);
    localparam logic             c_vs_active  = (V_SYNC_POL != 0);

    logic [CNT_W-1:0]   r_hctr;
    logic [CNT_W-1:0]   r_vctr;
    logic               r_hsync;
    logic               r_vsync;
    logic [FRAME_W-1:0] r_frame_count;

    logic [CNT_W-1:0]   w_h_next;
    logic [CNT_W-1:0]   w_v_next;
    logic               w_hsync_next;
    logic               w_vsync_next;
    logic               w_frame_wrap;

    // Next raster position; the line counter only moves at the end of a line.
    always_comb begin
        w_h_next = r_hctr + CNT_W'(1);
        w_v_next = r_vctr;
        if (r_hctr == c_h_last) begin
            w_h_next = '0;
            if (r_vctr == c_v_last) begin
                w_v_next = '0;
            end else begin
                w_v_next = r_vctr + CNT_W'(1);
            end
        end
    end

    // Sync decoded from the next position so the registered value lines up
    // with the counters it describes.
    always_comb begin
        w_hsync_next = ((w_h_next >= c_hs_start) && (w_h_next <= c_hs_end)) ? c_hs_active : ~c_hs_active;
        w_vsync_next = ((w_v_next >= c_vs_start) && (w_v_next <= c_vs_end)) ? c_vs_active : ~c_vs_active;
        w_frame_wrap = (w_h_next == '0) && (w_v_next == '0);
    end

    // Raster state: reset parks on the last pixel of the frame so the first
    // enabled edge lands exactly on (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hctr        <= c_h_last;
            r_vctr        <= c_v_last;
            r_hsync       <= ~c_hs_active;
            r_vsync       <= ~c_vs_active;
            r_frame_count <= '1;
        end else if (ce) begin
            r_hctr  <= w_h_next;
            r_vctr  <= w_v_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + FRAME_W'(1);
            end
        end
    end

    // Remaining outputs are pure decodes of the counter flops.
    always_comb begin
        pixel_x     = r_hctr;
        pixel_y     = r_vctr;
        hblank      = (r_hctr >= c_h_disp);
        vblank      = (r_vctr >= c_v_disp);
        video_on    = ~hblank & ~vblank;
        hsync       = r_hsync;
        vsync       = r_vsync;
        line_start  = (r_hctr == '0);
        frame_start = (r_hctr == '0) && (r_vctr == '0);
        frame_count = r_frame_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen: default mode,
//                small mode, pixel-enable throttling and narrow frame count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default-mode instance
    logic        rst_d, ce_d;
    logic [11:0] d_x, d_y;
    logic        d_vo, d_hb, d_vb, d_hs, d_vs, d_ls, d_fs;
    logic [15:0] d_fc;
    // Small-mode instance, free-running checks
    logic        rst_s, ce_s;
    logic [11:0] s_x, s_y;
    logic        s_vo, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs;
    logic [15:0] s_fc;
    // Small-mode instance, throttled by ce
    logic        rst_c, ce_c;
    logic [11:0] c_x, c_y;
    logic        c_vo, c_hb, c_vb, c_hs, c_vs, c_ls, c_fs;
    logic [15:0] c_fc;
    // Small-mode instance, 2-bit frame counter
    logic        rst_f, ce_f;
    logic [11:0] f_x, f_y;
    logic        f_vo, f_hb, f_vb, f_hs, f_vs, f_ls, f_fs;
    logic [1:0]  f_fc;

    vga_timing_gen u_d (
        .clk(clk), .rst(rst_d), .ce(ce_d), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_vo), .hblank(d_hb), .vblank(d_vb), .hsync(d_hs), .vsync(d_vs),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0)
    ) u_s (
        .clk(clk), .rst(rst_s), .ce(ce_s), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_vo), .hblank(s_hb), .vblank(s_vb), .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0)
    ) u_c (
        .clk(clk), .rst(rst_c), .ce(ce_c), .pixel_x(c_x), .pixel_y(c_y),
        .video_on(c_vo), .hblank(c_hb), .vblank(c_vb), .hsync(c_hs), .vsync(c_vs),
        .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .FRAME_W(2)
    ) u_f (
        .clk(clk), .rst(rst_f), .ce(ce_f), .pixel_x(f_x), .pixel_y(f_y),
        .video_on(f_vo), .hblank(f_hb), .vblank(f_vb), .hsync(f_hs), .vsync(f_vs),
        .line_start(f_ls), .frame_start(f_fs), .frame_count(f_fc)
    );

    typedef struct {
        logic rst;
        logic ce;
        int   x;
        int   y;
        logic vo, hb, vb, hs, vs, ls, fs;
        int   fc;
    } vec_t;

    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected small-mode state t enabled edges after the first (0,0).
    task automatic chk_small(input string tag, input int t,
                             input logic [11:0] x, input logic [11:0] y,
                             input logic vo, input logic hb, input logic vb,
                             input logic hs, input logic vs, input logic ls, input logic fs);
        int   ex, ey;
        logic evo, ehb, evb, ehs, evs, els, efs;
        ex  = t % 14;
        ey  = (t / 14) % 8;
        ehb = (ex >= 8);
        evb = (ey >= 4);
        evo = !ehb && !evb;
        ehs = !(ex >= 10 && ex <= 12);
        evs = !(ey >= 5 && ey <= 6);
        els = (ex == 0);
        efs = (ex == 0) && (ey == 0);
        chk(tag, {1'b0, x, y, vo, hb, vb, hs, vs, ls, fs},
                 {1'b0, 12'(ex), 12'(ey), evo, ehb, evb, ehs, evs, els, efs});
    endtask

    initial begin
        int t;
        int vs_cnt, glitch;
        logic prev_vs;
        int fs_hi;
        int nfs;
        int fc_seen [5];
        int cnt_vo, cnt_hs, first_hs, last_hs, cnt_ls, ls_x;

        //           rst   ce    x   y  vo    hb    vb    hs    vs    ls    fs    fc
        tbl[0] = '{1'b1, 1'b1, 13, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFFFF};
        tbl[1] = '{1'b1, 1'b0, 13, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFFFF};
        tbl[2] = '{1'b0, 1'b0, 13, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'hFFFF};
        tbl[3] = '{1'b0, 1'b1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[4] = '{1'b0, 1'b0,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[5] = '{1'b0, 1'b1,  1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[6] = '{1'b0, 1'b1,  2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};

        rst_d = 1'b1; ce_d = 1'b0;
        rst_s = 1'b1; ce_s = 1'b0;
        rst_c = 1'b1; ce_c = 1'b0;
        rst_f = 1'b1; ce_f = 1'b0;
        step();
        step();

        // ---------------- default mode: reset, release, one line ----------
        ce_d = 1'b1;
        step();
        chk("d_reset_xy", {8'd0, d_x, d_y}, {8'd0, 12'd1039, 12'd665});
        chk("d_reset_flags", {25'd0, d_vo, d_hb, d_vb, d_hs, d_vs, d_ls, d_fs},
                             {25'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("d_reset_fc", {16'd0, d_fc}, 32'h0000FFFF);
        rst_d = 1'b0;
        step();
        chk("d_first_xy", {8'd0, d_x, d_y}, 32'd0);
        chk("d_first_flags", {28'd0, d_vo, d_ls, d_fs, d_hs}, {28'd0, 1'b1, 1'b1, 1'b1, 1'b0});
        chk("d_first_fc", {16'd0, d_fc}, 32'd0);
        cnt_vo = 0; cnt_hs = 0; first_hs = -1; last_hs = -1; cnt_ls = 0; ls_x = -1;
        for (int i = 0; i < 1040; i++) begin
            if (d_vo) cnt_vo++;
            if (d_hs) begin
                cnt_hs++;
                if (first_hs < 0) first_hs = int'(d_x);
                last_hs = int'(d_x);
            end
            if (d_ls) begin
                cnt_ls++;
                ls_x = int'(d_x);
            end
            step();
        end
        chk("d_line_period_xy", {8'd0, d_x, d_y}, {8'd0, 12'd0, 12'd1});
        chk("d_video_on_cycles", cnt_vo, 800);
        chk("d_hsync_cycles", cnt_hs, 120);
        chk("d_hsync_first_x", first_hs, 856);
        chk("d_hsync_last_x", last_hs, 975);
        chk("d_line_start_count", cnt_ls, 1);
        chk("d_line_start_x", ls_x, 0);
        ce_d = 1'b0;

        // ---------------- small mode: table vectors -----------------------
        for (int i = 0; i < 7; i++) begin
            rst_s = tbl[i].rst;
            ce_s  = tbl[i].ce;
            step();
            chk($sformatf("s_tbl%0d_state", i),
                {1'b0, s_x, s_y, s_vo, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs},
                {1'b0, 12'(tbl[i].x), 12'(tbl[i].y), tbl[i].vo, tbl[i].hb, tbl[i].vb,
                 tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs});
            chk($sformatf("s_tbl%0d_fc", i), {16'd0, s_fc}, 32'(tbl[i].fc));
        end

        // ---------------- small mode: three frames ------------------------
        ce_s = 1'b1;
        vs_cnt = 0; glitch = 0; prev_vs = s_vs;
        for (t = 3; t <= 336; t++) begin
            step();
            chk_small("s_run", t, s_x, s_y, s_vo, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs);
            if (t < 112 && !s_vs) vs_cnt++;
            if (s_vs !== prev_vs && s_x != 12'd0) glitch++;
            prev_vs = s_vs;
            if (t % 112 == 0) chk("s_frame_count", {16'd0, s_fc}, 32'(t / 112));
        end
        chk("s_vsync_low_cycles", vs_cnt, 28);
        chk("s_vsync_toggle_off_x0", glitch, 0);

        // ---------------- small mode: reset inside vsync ------------------
        for (int i = 0; i < 89; i++) step();
        chk("s_pre_rst_pos", {9'd0, s_x, s_y, s_hs, s_vs}, {9'd0, 12'd5, 12'd6, 1'b1, 1'b0});
        rst_s = 1'b1;
        step();
        chk("s_midrst_state", {1'b0, s_x, s_y, s_vo, s_hb, s_vb, s_hs, s_vs, s_ls, s_fs},
                              {1'b0, 12'd13, 12'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("s_midrst_fc", {16'd0, s_fc}, 32'h0000FFFF);
        rst_s = 1'b0;
        ce_s  = 1'b0;

        // ---------------- small mode: ce one cycle in three ---------------
        rst_c = 1'b0;
        step();
        chk("c_park_hold", {8'd0, c_x, c_y}, {8'd0, 12'd13, 12'd7});
        fs_hi = 0;
        for (int k = 0; k < 116; k++) begin
            ce_c = 1'b1;
            step();
            chk_small("c_en", k, c_x, c_y, c_vo, c_hb, c_vb, c_hs, c_vs, c_ls, c_fs);
            if (c_fs) fs_hi++;
            ce_c = 1'b0;
            step();
            chk_small("c_hold1", k, c_x, c_y, c_vo, c_hb, c_vb, c_hs, c_vs, c_ls, c_fs);
            if (c_fs) fs_hi++;
            step();
            chk_small("c_hold2", k, c_x, c_y, c_vo, c_hb, c_vb, c_hs, c_vs, c_ls, c_fs);
            if (c_fs) fs_hi++;
        end
        chk("c_frame_start_cycles", fs_hi, 6);
        chk("c_frame_count", {16'd0, c_fc}, 32'd1);

        // ---------------- small mode: 2-bit frame counter -----------------
        rst_f = 1'b0;
        ce_f  = 1'b1;
        nfs = 0;
        for (int i = 0; i < 560; i++) begin
            step();
            if (f_fs) begin
                if (nfs < 5) fc_seen[nfs] = int'(f_fc);
                nfs++;
            end
        end
        chk("f_frame_starts", nfs, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("f_fc_at_start%0d", i), fc_seen[i], i % 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
